// File: rtl/io_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw pin levels in, conditioned
// levels, event pulses and the synchronised reset out.
interface io_conditioner_if #(
    parameter int N = 12
);
    logic [N-1:0] raw_in;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] long_press;
    logic         any_change;
    logic         rst_sync_;

    modport master (
        output raw_in,
        input  level, rise, fall, long_press, any_change, rst_sync_
    );

    modport slave (
        input  raw_in,
        output level, rise, fall, long_press, any_change, rst_sync_
    );
endinterface

// File: rtl/io_conditioner.sv
// Board input conditioner: per-channel polarity fix, synchroniser, debouncer,
// edge and long-press pulses, plus an async-assert/sync-release reset.
module io_cond_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_,
    input  logic s_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_o,
    output logic chg_d_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d;
    logic          rise_q, fall_q, long_q;
    logic          long_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s_i != level_q) begin
            if (cnt_q == DB_LAST) level_d = s_i;
            else                  cnt_d   = cnt_q + 1'b1;
        end
        // Hold count is 0 in the rise cycle and saturates so a press pulses once.
        hold_d = '0;
        if (level_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        long_d = level_q & level_d & (hold_q == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
            long_q  <= long_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign long_o  = long_q;
    assign chg_d_o = level_d ^ level_q;
endmodule

module io_conditioner #(
    parameter int           N               = 12,
    parameter int           SYNC_STAGES     = 2,
    parameter int           DEBOUNCE_CYCLES = 500000,
    parameter int           LONG_CYCLES     = 50000000,
    parameter logic [N-1:0] INVERT          = N'(3)
) (
    input  logic        clk,
    input  logic        rst_,
    io_conditioner_if.slave io
);
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [SYNC_STAGES-1:0]        rs_q;
    logic [N-1:0] level_w, rise_w, fall_w, long_w, chg_d;
    logic         any_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sync_q <= '0;
            rs_q   <= '0;
            any_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io.raw_in ^ INVERT};
            rs_q   <= {rs_q[SYNC_STAGES-2:0], 1'b1};
            any_q  <= |chg_d;
        end
    end

    io_cond_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .LONG_CYCLES    (LONG_CYCLES)
    ) u_lane [N-1:0] (
        .clk    (clk),
        .rst_   (rst_),
        .s_i    (sync_q[SYNC_STAGES-1]),
        .level_o(level_w),
        .rise_o (rise_w),
        .fall_o (fall_w),
        .long_o (long_w),
        .chg_d_o(chg_d)
    );

    assign io.level      = level_w;
    assign io.rise       = rise_w;
    assign io.fall       = fall_w;
    assign io.long_press = long_w;
    assign io.any_change = any_q;
    assign io.rst_sync_  = rs_q[SYNC_STAGES-1];
endmodule

// File: tb/tb_io_conditioner.sv
// Bench for io_conditioner: directed scenarios with literal expectations plus
// a random phase, all compared every cycle against a window-based model.
module tb_io_conditioner;
    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int LC = 10;
    localparam logic [N-1:0] INV = 4'b0011;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    io_conditioner_if #(.N(N)) io();

    io_conditioner #(
        .N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
        .LONG_CYCLES(LC), .INVERT(INV)
    ) dut (
        .clk (clk),
        .rst_(rst_),
        .io  (io)
    );

    int checks = 0;
    int errors = 0;

    // Model: e = edges since reset release; xlog[k] = normalised input taken
    // at edge k+1; slog[c] = synchronised value seen during cycle c.
    int           e;
    logic [N-1:0] xlog[$];
    logic [N-1:0] slog[$];
    logic [N-1:0] m_level, m_rise, m_fall, m_long;
    int           rise_cyc[N];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0;
        xlog.delete();
        slog.delete();
        slog.push_back('0);
        m_level = '0; m_rise = '0; m_fall = '0; m_long = '0;
        for (int i = 0; i < N; i++) rise_cyc[i] = -1;
    endtask

    task automatic model_step();
        logic [N-1:0] tmp;
        logic         old;
        bit           alldiff;
        e++;
        xlog.push_back(io.raw_in ^ INV);
        for (int i = 0; i < N; i++) begin
            old = m_level[i];
            // Level flips once the last DC synchronised samples all disagree with it.
            if (e >= DC) begin
                alldiff = 1;
                for (int k = e - DC; k < e; k++) begin
                    tmp = slog[k];
                    if (tmp[i] == old) alldiff = 0;
                end
                if (alldiff) m_level[i] = ~old;
            end
            m_rise[i] = !old && m_level[i];
            m_fall[i] = old && !m_level[i];
            if (m_rise[i]) rise_cyc[i] = e;
            if (m_fall[i]) rise_cyc[i] = -1;
            m_long[i] = m_level[i] && (rise_cyc[i] >= 0) && (e - rise_cyc[i] == LC);
        end
        tmp = (e >= SS) ? xlog[e-SS] : '0;
        slog.push_back(tmp);
    endtask

    task automatic compare_all();
        chk("level", 32'(io.level), 32'(m_level));
        chk("rise", 32'(io.rise), 32'(m_rise));
        chk("fall", 32'(io.fall), 32'(m_fall));
        chk("long_press", 32'(io.long_press), 32'(m_long));
        chk("any_change", 32'(io.any_change), 32'(|(m_rise | m_fall)));
        chk("rst_sync_", 32'(io.rst_sync_), 32'((rst_ && e >= SS) ? 1 : 0));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic assert_reset(input string tag);
        rst_ = 1'b0;
        model_reset();
        #1;
        chk({tag, "_level0"}, 32'(io.level), 0);
        chk({tag, "_pulses0"}, 32'(io.rise | io.fall | io.long_press), 0);
        chk({tag, "_any0"}, 32'(io.any_change), 0);
        chk({tag, "_rsync0"}, 32'(io.rst_sync_), 0);
    endtask

    task automatic release_and_check(input string tag);
        io.raw_in = '0;
        cycles(3);
        rst_ = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 1) chk({tag, "_rsync_e1"}, 32'(io.rst_sync_), 0);
            if (k == 2) chk({tag, "_rsync_e2"}, 32'(io.rst_sync_), 1);
            if (k == 5) chk({tag, "_level_e5"}, 32'(io.level), 0);
            if (k == 6) begin
                chk({tag, "_level_e6"}, 32'(io.level), 32'h3);
                chk({tag, "_rise_e6"}, 32'(io.rise), 32'h3);
                chk({tag, "_any_e6"}, 32'(io.any_change), 1);
            end
            if (k == 7) chk({tag, "_rise_e7"}, 32'(io.rise), 0);
        end
    endtask

    // Waits (bounded) for a rise on channel ch; returns edges waited or -1.
    task automatic wait_rise(input int ch, output int found);
        logic [N-1:0] r;
        found = -1;
        for (int k = 1; k <= 20 && found < 0; k++) begin
            cyc();
            r = io.rise;
            if (r[ch]) found = k;
        end
    endtask

    initial begin
        int found, nlong, longoff, nany, nr, nf, nl, rate;
        logic [N-1:0] v;
        io.raw_in = '0;
        model_reset();
        @(negedge clk);
        assert_reset("s1");
        release_and_check("s1");

        // Debounce latency and long press on channel 2.
        cycles(4);
        io.raw_in[2] = 1'b1;
        wait_rise(2, found);
        chk("s2_rise_latency", 32'(found), 6);
        chk("s2_level2", 32'(io.level[2]), 1);
        nlong = 0; longoff = -1;
        for (int off = 1; off <= 15; off++) begin
            cyc();
            if (off == 1) chk("s2_rise_1cyc", 32'(io.rise[2]), 0);
            if (io.long_press[2]) begin nlong++; longoff = off; end
        end
        chk("s4_long_offset", 32'(longoff), 10);
        chk("s4_long_count", 32'(nlong), 1);

        // Fall forced so level is 0 in cycle T+9: no long press.
        io.raw_in[2] = 1'b0;
        cycles(12);
        io.raw_in[2] = 1'b1;
        wait_rise(2, found);
        cycles(3);
        io.raw_in[2] = 1'b0;
        nlong = 0;
        for (int off = 4; off <= 18; off++) begin
            cyc();
            if (off == 8) chk("s4_level_t8", 32'(io.level[2]), 1);
            if (off == 9) chk("s4_level_t9", 32'(io.level[2]), 0);
            if (io.long_press[2]) nlong++;
        end
        chk("s4_no_long", 32'(nlong), 0);

        // Glitch of 3 cycles rejected, 4-cycle pulse accepted.
        io.raw_in[3] = 1'b1;
        cycles(3);
        io.raw_in[3] = 1'b0;
        nr = 0; nf = 0; nl = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            nr += int'(io.rise[3]); nf += int'(io.fall[3]); nl += int'(io.level[3]);
        end
        chk("s3_glitch_activity", 32'(nr + nf + nl), 0);
        io.raw_in[3] = 1'b1;
        cycles(4);
        io.raw_in[3] = 1'b0;
        nr = 0; nf = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            nr += int'(io.rise[3]); nf += int'(io.fall[3]);
        end
        chk("s3_pulse_rise", 32'(nr), 1);
        chk("s3_pulse_fall", 32'(nf), 1);

        // Simultaneous rise on channels 2 and 3.
        io.raw_in[2] = 1'b1;
        io.raw_in[3] = 1'b1;
        nany = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 6) chk("s5_rise_both", 32'(io.rise), 32'hC);
            nany += int'(io.any_change);
        end
        chk("s5_any_once", 32'(nany), 1);

        // Reset during hold count (ch3) and pending debounce (ch2).
        io.raw_in[2] = 1'b0;
        cycles(2);
        assert_reset("s6");
        cycles(4);
        release_and_check("s6");

        // Random phase with varying toggle rates and occasional resets.
        rate = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rate = 2;
                    1: rate = 10;
                    default: rate = 60;
                endcase
            end
            v = io.raw_in;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, rate - 1) == 0) v[i] = ~v[i];
            io.raw_in = v;
            if ($urandom_range(0, 699) == 0) begin
                assert_reset("rnd");
                cycles(int'($urandom_range(1, 3)));
                rst_ = 1'b1;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_conditioner.md
Name: io_conditioner

Overview:
- Parametrised input-conditioning block for board push buttons, switches and the external reset request.
- Per channel: polarity normalisation, multi-stage synchroniser, debouncer, edge pulses and long-press detection.
- Also produces a synchronously released reset for downstream logic.
- Sits directly behind the board top level, between raw pins and the core; replaces ad-hoc use of raw key/switch levels.

Parameters:
- N, 12, number of input channels (2 keys + 10 switches on the DE10-Lite).
- SYNC_STAGES, 2, synchroniser flops per channel and for the reset release; must be >= 2.
- DEBOUNCE_CYCLES, 500000, consecutive cycles a new synchronised value must persist before acceptance (10 ms at 50 MHz); must be >= 1.
- LONG_CYCLES, 50000000, cycles the debounced level must stay 1 before a long-press pulse (1 s at 50 MHz); must be >= 1.
- INVERT, N'b11, per-channel mask; a 1 bit means the raw pin is active-low and is inverted before synchronisation.

Ports:
- clk  input  1  system clock.
- rst_  input  1  asynchronous active-low reset.
- raw_in  input  N  raw asynchronous pin levels.
- level  output  N  debounced, active-high channel level.
- rise  output  N  one-cycle pulse when level goes 0->1.
- fall  output  N  one-cycle pulse when level goes 1->0.
- long_press  output  N  one-cycle pulse after level has been held at 1 for LONG_CYCLES cycles.
- any_change  output  1  OR-reduction of (rise | fall).
- rst_sync_  output  1  active-low reset: asserts asynchronously, releases synchronously.

Behaviour:
- Reset (rst_ low, asynchronous): all sync flops, debounce counters, hold counters and level are cleared to 0. Outputs level, rise, fall, long_press and any_change are 0. rst_sync_ is 0.
- rst_sync_: a SYNC_STAGES-deep shift register of 1s. It goes 1 on the SYNC_STAGES-th rising clk edge after rst_ deasserts.
- Polarity: x[i] = raw_in[i] ^ INVERT[i], applied before the first sync flop.
- Synchroniser: x passes through SYNC_STAGES flops; s[i] is the last stage.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - When s == level: counter clears to 0.
  - When s != level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - When s != level and counter == DEBOUNCE_CYCLES-1: level <= s and counter <= 0.
  - Any glitch back to the old value restarts the count.
  - DEBOUNCE_CYCLES=1 gives no filtering.
- Latency: a raw step held stable appears on level exactly SYNC_STAGES + DEBOUNCE_CYCLES clk edges after the first edge that samples it.
- rise and fall: registered, asserted in the same cycle level takes its new value, for exactly one cycle. They are mutually exclusive per channel.
- Long press, per channel, hold counter width $clog2(LONG_CYCLES+1):
  - Counter is cleared while level == 0 and on the rise cycle.
  - Counter increments while level == 1 and saturates at LONG_CYCLES.
  - If rise is asserted in cycle T, long_press asserts in cycle T+LONG_CYCLES iff level is 1 in every cycle T..T+LONG_CYCLES.
  - Only one pulse per press; no auto-repeat until level falls and rises again.
  - long_press never coincides with fall.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle; any_change is 1 in that cycle.
- Reset mid-operation (pending debounce or hold count): everything clears immediately with no spurious pulse. After release, channels whose normalised input is 1 produce a normal rise after SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- No combinational path from raw_in to any output.

Test Plan:
All scenarios use N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, INVERT=4'b0011.

1. Reset: hold rst_=0 with raw_in=4'b0000 -> all outputs 0. Release rst_ -> rst_sync_=1 on the 2nd edge. Channels 0 and 1 (inverted, so normalised 1) rise after 6 edges with level=4'b0011, rise=4'b0011 for one cycle, any_change=1.
2. Debounce pass: after settling, raw_in[2] 0->1 held -> level[2]=1 and rise[2]=1 exactly 6 edges later, rise[2] high for 1 cycle.
3. Glitch rejection: raw_in[3] high for 3 cycles then low -> level[3], rise[3] and fall[3] stay 0. Then a 4-cycle-wide pulse -> level[3] rises and later falls, one rise and one fall pulse.
4. Long press: rise[2] in cycle T, raw held -> long_press[2]=1 only in cycle T+10, none after. If a fall is forced so level[2]=0 in cycle T+9 -> no long_press.
5. Simultaneous: raw_in[2] and raw_in[3] toggle on the same edge -> rise=4'b1100 in one cycle, any_change=1 for exactly that cycle.
6. Reset mid-count: assert rst_ during a debounce count and during a hold count -> outputs 0 asynchronously, no pulses. After release, behaviour matches scenario 1.
